inst_fetch_cache: RTL and testbench

//  Parametrised instruction-fetch memory: a direct-mapped, read-only I-cache in front of pmem_read (DPI-C).

---
 rtl/inst_fetch_cache_pkg.sv | 27 ++
 rtl/inst_fetch_cache_line_ram.sv | 57 +++++
 rtl/inst_fetch_cache.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_cache.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_cache_pkg.sv
// Shared definitions for the instruction-fetch cache: FSM encodings, response
// record and address-field width helpers.
package inst_fetch_cache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } resp_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int line_words, input int num_lines);
        return 32 - 2 - off_w(line_words) - idx_w(num_lines);
    endfunction

endpackage

// File: rtl/inst_fetch_cache_line_ram.sv
// Line storage for the I-cache: word-granular data array, per-line tag array and
// valid bits with one write port and one combinational read port.
module inst_fetch_cache_line_ram
    import inst_fetch_cache_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    parameter  int NUM_LINES  = 16,
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int IDX_W      = idx_w(NUM_LINES),
    localparam int TAG_W      = tag_w(LINE_WORDS, NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             tag_wr,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             valid_set,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic [31:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid
);

    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
        if (tag_wr) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    // Flush beats a simultaneous line install so a flushed refill stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (valid_set) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[{rd_idx, rd_off}];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache with valid/ready request and response
// handshakes, critical-word-first refill from a word-wide memory read port.
module inst_fetch_cache
    import inst_fetch_cache_pkg::*;
#(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 16,
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_pc,
    output logic        resp_err,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W   = off_w(LINE_WORDS);
    localparam int IDX_W   = idx_w(NUM_LINES);
    localparam int TAG_W   = tag_w(LINE_WORDS, NUM_LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;

    logic [1:0]       state;
    logic [OFF_W-1:0] cnt;
    logic             flushed;
    resp_t            resp_q;
    logic [31:0]      fill_pc;
    logic [31:0]      crit_word;

    logic [OFF_W-1:0] req_off, fill_off, fill_word_off;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [31:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             accept, req_err, req_hit, refilling, fill_last;

    assign req_off  = req_pc[2 +: OFF_W];
    assign req_idx  = req_pc[2 + OFF_W +: IDX_W];
    assign req_tag  = req_pc[TAG_LSB +: TAG_W];
    assign fill_off = fill_pc[2 +: OFF_W];
    assign fill_idx = fill_pc[2 + OFF_W +: IDX_W];
    assign fill_tag = fill_pc[TAG_LSB +: TAG_W];

    assign refilling     = (state == ST_REFILL);
    // Offset arithmetic wraps inside the line, giving critical-word-first order.
    assign fill_word_off = fill_off + cnt;
    assign fill_last     = refilling && (cnt == OFF_W'(LINE_WORDS - 1));

    assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && resp_ready);
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_pc[1:0] != 2'b00) || (req_pc < ADDR_BASE);
    assign req_hit   = rd_valid && (rd_tag == req_tag);

    assign mem_rd   = refilling;
    assign mem_addr = {fill_pc[31:2+OFF_W], fill_word_off, 2'b00};

    inst_fetch_cache_line_ram #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_line_ram (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (refilling),
        .wr_idx    (fill_idx),
        .wr_off    (fill_word_off),
        .wr_data   (mem_rdata),
        .tag_wr    (fill_last),
        .wr_tag    (fill_tag),
        .valid_set (fill_last && !flushed),
        .rd_idx    (req_idx),
        .rd_off    (req_off),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            flushed  <= 1'b0;
            resp_q   <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (refilling) begin
                cnt <= cnt + OFF_W'(1);
                if (flush) begin
                    flushed <= 1'b1;
                end
            end
            if (accept) begin
                if (req_err) begin
                    state  <= ST_RESP;
                    resp_q <= '{inst: 32'h0, pc: req_pc, err: 1'b1};
                end else if (req_hit) begin
                    state   <= ST_RESP;
                    resp_q  <= '{inst: rd_data, pc: req_pc, err: 1'b0};
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    state    <= ST_REFILL;
                    cnt      <= '0;
                    flushed  <= 1'b0;
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end else if (fill_last) begin
                state  <= ST_RESP;
                resp_q <= '{inst: crit_word, pc: fill_pc, err: 1'b0};
            end else if ((state == ST_RESP) && resp_ready) begin
                state <= ST_IDLE;
            end
        end
    end

    // The first word fetched is the requested one; keep it for the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_pc <= req_pc;
        end
        if (refilling && (cnt == '0)) begin
            crit_word <= mem_rdata;
        end
    end

    assign resp_valid = (state == ST_RESP);
    assign resp_inst  = resp_q.inst;
    assign resp_pc    = resp_q.pc;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Self-checking bench for inst_fetch_cache: directed scenarios plus a randomized
// phase, all compared every cycle against a transaction-level cache model.
module tb_inst_fetch_cache;

    localparam int          LW   = 4;
    localparam int          NL   = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] LINE_B = 32'(4 * LW);
    localparam logic [31:0] LWL    = 32'(LW);
    localparam logic [31:0] NLL    = 32'(NL);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;
    logic [31:0] req_pc = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_rd;
    logic [31:0] resp_inst, resp_pc, hit_cnt, miss_cnt, mem_addr, mem_rdata;

    int checks   = 0;
    int errors   = 0;
    int rd_count = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    inst_fetch_cache #(
        .LINE_WORDS (LW),
        .NUM_LINES  (NL),
        .ADDR_BASE  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    bit          m_have = 0, m_refill = 0, m_flushed = 0, m_acc = 0;
    int          m_wait = 0;
    logic [31:0] m_fill_pc = 0, m_hits = 0, m_misses = 0;
    logic [31:0] e_inst = 0, e_pc = 0;
    bit          e_err = 0;
    logic [31:0] m_line;
    int          m_li;

    function automatic bit exp_valid();
        return m_have && (m_wait == 0);
    endfunction

    function automatic bit exp_ready();
        return !m_have || ((m_wait == 0) && resp_ready);
    endfunction

    function automatic logic [31:0] exp_addr();
        logic [31:0] lb, crit, k;
        lb   = (m_fill_pc / LINE_B) * LINE_B;
        crit = (m_fill_pc / 32'd4) % LWL;
        k    = LWL - 32'(m_wait);
        return lb + 32'd4 * ((crit + k) % LWL);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_have = 0; m_wait = 0; m_refill = 0; m_flushed = 0;
            m_hits = 0; m_misses = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else begin
            m_acc = req_valid && exp_ready();
            if (exp_valid() && resp_ready) m_have = 0;
            if (m_refill) begin
                if (flush) m_flushed = 1;
                m_wait--;
                if (m_wait == 0) begin
                    m_refill = 0;
                    if (!m_flushed) begin
                        m_line = m_fill_pc / LINE_B;
                        m_li = int'(m_line % NLL);
                        m_valid[m_li] = 1;
                        m_tag[m_li] = m_line / NLL;
                    end
                end
            end
            if (m_acc) begin
                m_line = req_pc / LINE_B;
                m_li   = int'(m_line % NLL);
                m_have = 1;
                e_pc   = req_pc;
                if ((req_pc % 32'd4) != 0 || req_pc < BASE) begin
                    e_err = 1; e_inst = 32'h0; m_wait = 0;
                end else if (m_valid[m_li] && m_tag[m_li] == m_line / NLL) begin
                    m_hits++; e_err = 0; e_inst = mem_word(req_pc); m_wait = 0;
                end else begin
                    m_misses++; e_err = 0; e_inst = mem_word(req_pc);
                    m_wait = LW; m_refill = 1; m_flushed = 0; m_fill_pc = req_pc;
                end
            end
            if (flush) foreach (m_valid[i]) m_valid[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready()));
            chk("resp_valid", 32'(resp_valid), 32'(exp_valid()));
            if (exp_valid()) begin
                chk("resp_inst", resp_inst, e_inst);
                chk("resp_pc", resp_pc, e_pc);
                chk("resp_err", 32'(resp_err), 32'(e_err));
            end
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
            chk("mem_rd", 32'(mem_rd), 32'(m_refill));
            if (mem_rd) rd_count++;
            if (m_refill) chk("mem_addr", mem_addr, exp_addr());
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic [31:0] pc);
        int n = 0;
        bit a = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pc    = pc;
        while (!a && n < 100) begin
            @(negedge clk);
            a = req_ready;
            n++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!a) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout: pc %h not accepted, expected accept within 100 cycles", pc);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 100);
        if (!resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_timeout: resp_valid 0 after %0d cycles, expected 1", lat);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h7FFF_FF00 + 32'd4 * 32'($urandom_range(0, 63));
        if (r == 1) return BASE + 32'd4 * 32'($urandom_range(0, 255)) + 32'd2;
        return BASE + 32'd4 * 32'($urandom_range(0, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit acc_n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_inst", resp_inst, 32'h0);
        chk("rst_resp_pc", resp_pc, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);

        // cold miss
        do_req(32'h8000_0000); wait_resp(lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_inst", resp_inst, 32'hDA5A_1234);
        chk("t1_miss_cnt", miss_cnt, 32'd1);
        chk("t1_reads", 32'(rd_count), 32'd4);

        // hit in the freshly filled line
        do_req(32'h8000_0004); wait_resp(lat);
        chk("t2_latency", 32'(lat), 32'd1);
        chk("t2_inst", resp_inst, 32'hDA5A_1230);
        chk("t2_hit_cnt", hit_cnt, 32'd1);
        chk("t2_reads", 32'(rd_count), 32'd4);

        // misaligned
        do_req(32'h8000_000A); wait_resp(lat);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_err", 32'(resp_err), 32'd1);
        chk("t3_inst", resp_inst, 32'h0);
        chk("t3_hit_cnt", hit_cnt, 32'd1);
        chk("t3_miss_cnt", miss_cnt, 32'd1);
        chk("t3_reads", 32'(rd_count), 32'd4);

        // consumer stall
        do_req(32'h8000_0008);
        resp_ready = 1'b0;
        wait_resp(lat);
        chk("t4_latency", 32'(lat), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(resp_valid), 32'd1);
            chk("t4_hold_inst", resp_inst, 32'hDA5A_123C);
            chk("t4_hold_pc", resp_pc, 32'h8000_0008);
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("t4_after_valid", 32'(resp_valid), 32'd0);
        chk("t4_hit_cnt", hit_cnt, 32'd2);

        // flush during refill
        do_req(32'h8000_0040);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_resp(lat);
        chk("t5_inst", resp_inst, 32'hDA5A_1274);
        chk("t5_miss_cnt", miss_cnt, 32'd2);
        do_req(32'h8000_0040); wait_resp(lat);
        chk("t5_re_latency", 32'(lat), 32'd5);
        chk("t5_re_miss_cnt", miss_cnt, 32'd3);

        // index conflict
        do_req(32'h8000_0000); wait_resp(lat);
        chk("t6a_latency", 32'(lat), 32'd5);
        do_req(32'h8000_0100); wait_resp(lat);
        chk("t6b_latency", 32'(lat), 32'd5);
        chk("t6b_inst", resp_inst, 32'hDA5A_1334);
        do_req(32'h8000_0000); wait_resp(lat);
        chk("t6c_latency", 32'(lat), 32'd5);
        chk("t6_miss_cnt", miss_cnt, 32'd6);
        chk("t6_hit_cnt", hit_cnt, 32'd2);

        // randomized traffic with back-to-back requests, stalls and flushes
        @(posedge clk); #1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_n = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc_n || !req_valid) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_pc    = rand_pc();
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
        end
        req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        repeat (10) @(posedge clk);

        // reset in the middle of a refill
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        do_req(32'h8000_0300);
        @(posedge clk); #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("t8_rst_valid", 32'(resp_valid), 32'd0);
        chk("t8_rst_ready", 32'(req_ready), 32'd1);
        chk("t8_rst_miss_cnt", miss_cnt, 32'd0);
        chk("t8_rst_hit_cnt", hit_cnt, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("t8_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req(32'h8000_0300); wait_resp(lat);
        chk("t8_latency", 32'(lat), 32'd5);
        chk("t8_inst", resp_inst, 32'hDA5A_1134);
        chk("t8_miss_cnt", miss_cnt, 32'd1);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
